// File: rtl/usb_rx_pkt_ctrl.sv
// Packet sequencer on the USB RX FIFO read port: pops and checks the PID, streams the
// payload with backpressure, enforces per-type length rules and reports one summary per packet.
module usb_rx_pkt_ctrl #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_r_data,
  output logic             fifo_r_enable,
  input  logic             rcving,
  input  logic             r_error,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  input  logic             byte_ready,
  output logic             pkt_valid,
  output logic [3:0]       pkt_pid,
  output logic [1:0]       pkt_type,
  output logic [LEN_W-1:0] pkt_len,
  output logic             pkt_err,
  output logic [1:0]       pkt_err_code
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_PID  = 2'b01,
    ERR_LEN  = 2'b10,
    ERR_RX   = 2'b11
  } err_t;

  state_t           state_q, state_d;
  logic [3:0]       pid_q, pid_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [TO_W-1:0]  to_q, to_d;
  err_t             err_q, err_d;
  err_t             len_code, final_code;
  logic             pop, deliver;

  logic [3:0]       pkt_pid_q;
  logic [1:0]       pkt_type_q;
  logic [LEN_W-1:0] pkt_len_q;
  err_t             pkt_code_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pid_d   = pid_q;
    len_d   = len_q;
    to_d    = to_q;
    err_d   = err_q;
    pop     = 1'b0;
    deliver = 1'b0;

    unique case (state_q)
      IDLE: begin
        len_d = '0;
        to_d  = '0;
        err_d = ERR_NONE;
        if (!fifo_empty) begin
          pop   = 1'b1;
          pid_d = fifo_r_data[3:0];
          if (fifo_r_data[7:4] == ~fifo_r_data[3:0]) begin
            state_d = PAYLOAD;
          end else begin
            err_d   = ERR_PID;
            state_d = DRAIN;
          end
        end
      end

      PAYLOAD: begin
        // Receiver error wins over everything else; the pending byte is left for DRAIN.
        if (r_error) begin
          if (err_q == ERR_NONE) err_d = ERR_RX;
          state_d = DRAIN;
        end else if (fifo_empty) begin
          if (!rcving) begin
            state_d = DONE;
          end else if (to_q == TO_W'(TIMEOUT - 1)) begin
            to_d    = TO_W'(TIMEOUT);
            if (err_q == ERR_NONE) err_d = ERR_RX;
            state_d = DONE;
          end else begin
            to_d = to_q + 1'b1;
          end
        end else if (len_q == LEN_W'(MAX_LEN)) begin
          if (err_q == ERR_NONE) err_d = ERR_LEN;
          state_d = DRAIN;
        end else if (byte_ready) begin
          pop     = 1'b1;
          deliver = 1'b1;
          len_d   = len_q + 1'b1;
          to_d    = '0;
        end
      end

      DRAIN: begin
        if (r_error && (err_q == ERR_NONE)) err_d = ERR_RX;
        if (!fifo_empty) begin
          pop  = 1'b1;
          to_d = '0;
        end else if (!rcving && !r_error) begin
          state_d = DONE;
        end
      end

      DONE: state_d = IDLE;
    endcase
  end

  // Length rule applies only when nothing else has gone wrong with the packet.
  always_comb begin
    len_code = ERR_NONE;
    case (pid_q[1:0])
      2'b01:   if (len_q != LEN_W'(2)) len_code = ERR_LEN;
      2'b10:   if (len_q != '0)        len_code = ERR_LEN;
      default: len_code = ERR_NONE;
    endcase
    final_code = (err_d != ERR_NONE) ? err_d : len_code;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      pid_q      <= '0;
      len_q      <= '0;
      to_q       <= '0;
      err_q      <= ERR_NONE;
      pkt_pid_q  <= '0;
      pkt_type_q <= '0;
      pkt_len_q  <= '0;
      pkt_code_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      len_q   <= len_d;
      to_q    <= to_d;
      err_q   <= err_d;
      if (state_d == DONE) begin
        pkt_pid_q  <= pid_q;
        pkt_type_q <= pid_q[1:0];
        pkt_len_q  <= len_q;
        pkt_code_q <= final_code;
      end
    end
  end

  // Pops are suppressed while reset is asserted so no FIFO byte is lost during reset.
  assign fifo_r_enable = pop & n_rst;
  assign byte_valid    = deliver & n_rst;
  assign byte_data     = byte_valid ? fifo_r_data : 8'h00;

  assign pkt_valid     = (state_q == DONE);
  assign pkt_pid       = pkt_pid_q;
  assign pkt_type      = pkt_type_q;
  assign pkt_len       = pkt_len_q;
  assign pkt_err_code  = pkt_code_q;
  assign pkt_err       = (pkt_code_q != ERR_NONE);

endmodule
